// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP core front end: PC source encodings,
// NOP word, two-word instruction prefix and fetch state enum.
package dsp_pkg;

    localparam logic [1:0] PC_BR   = 2'b00;
    localparam logic [1:0] PC_CALL = 2'b01;
    localparam logic [1:0] PC_RET  = 2'b10;
    localparam logic [1:0] PC_SEQ  = 2'b11;

    localparam logic [15:0] NOP_INSTR       = 16'h7F80;
    localparam logic [3:0]  TWO_WORD_PREFIX = 4'hF;

    typedef enum logic [1:0] {
        FETCH1 = 2'd0,
        FETCH2 = 2'd1,
        ISSUE  = 2'd2
    } fetch_state_t;

    function automatic logic is_two_word(input logic [15:0] word);
        return word[15:12] == TWO_WORD_PREFIX;
    endfunction

endpackage

// File: rtl/fetch_unit_return_stack.sv
// Hardware return stack: shift-register of return addresses, top at entry 0.
// Overflow drops the bottom entry; underflow keeps returning the bottom entry.
module return_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top
);

    logic [W-1:0] entries [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (push) begin
            entries[0] <= push_data;
            for (int i = 1; i < DEPTH; i++) entries[i] <= entries[i-1];
        end else if (pop) begin
            // bottom entry is left in place so it is duplicated upward
            for (int i = 0; i < DEPTH - 1; i++) entries[i] <= entries[i+1];
        end
    end

    assign top = entries[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IR/operand registers and next-PC selection.
// Return stack is present only when FETCH_STACK_EN is defined.
//
// state  | meaning
// FETCH1 | request first instruction word at fetch_pc
// FETCH2 | request operand word of a two-word instruction
// ISSUE  | instruction valid to decode; resolve next PC unless stalled
module fetch_unit
    import dsp_pkg::*;
#(
    parameter int PC_W        = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] pm_addr,
    output logic            pm_req,
    input  logic            pm_ack,
    input  logic [15:0]     pm_rdata,
    input  logic [1:0]      pcInMux_ctrl,
    input  logic            branch_taken,
    input  logic            stall,
    output logic [15:0]     instruction,
    output logic [7:0]      OP_dk,
    output logic [3:0]      OP_s,
    output logic [15:0]     operand,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc
);

    fetch_state_t    state, state_nxt;
    logic [PC_W-1:0] fetch_pc, fetch_pc_nxt;
    logic [PC_W-1:0] seq_pc, jump_pc;
    logic [PC_W-1:0] pc_q;
    logic [15:0]     ir, operand_q;
    logic            pm_req_q, instr_valid_q;
    logic            ack_ok, ir_load, op_load;

    // fetch_pc points at the last fetched word while in ISSUE
    assign seq_pc  = fetch_pc + PC_W'(1);
    assign jump_pc = operand_q[PC_W-1:0];
    assign ack_ok  = pm_ack & pm_req_q;

`ifdef FETCH_STACK_EN
    logic            stack_push, stack_pop;
    logic [PC_W-1:0] stack_top;

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_return_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (stack_push),
        .pop       (stack_pop),
        .push_data (seq_pc),
        .top       (stack_top)
    );
`endif

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        ir_load      = 1'b0;
        op_load      = 1'b0;
`ifdef FETCH_STACK_EN
        stack_push   = 1'b0;
        stack_pop    = 1'b0;
`endif
        case (state)
            FETCH1: begin
                if (ack_ok) begin
                    ir_load = 1'b1;
                    if (is_two_word(pm_rdata)) begin
                        fetch_pc_nxt = fetch_pc + PC_W'(1);
                        state_nxt    = FETCH2;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            FETCH2: begin
                if (ack_ok) begin
                    op_load   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    state_nxt    = FETCH1;
                    fetch_pc_nxt = seq_pc;
                    case (pcInMux_ctrl)
`ifdef FETCH_STACK_EN
                        PC_BR: begin
                            if (branch_taken) fetch_pc_nxt = jump_pc;
                        end
                        PC_CALL: begin
                            if (branch_taken) begin
                                stack_push   = 1'b1;
                                fetch_pc_nxt = jump_pc;
                            end
                        end
                        PC_RET: begin
                            stack_pop    = 1'b1;
                            fetch_pc_nxt = stack_top;
                        end
`else
                        // without a stack, call degrades to branch, return to sequential
                        PC_BR, PC_CALL: begin
                            if (branch_taken) fetch_pc_nxt = jump_pc;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            default: state_nxt = FETCH1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FETCH1;
            fetch_pc      <= '0;
            pc_q          <= '0;
            ir            <= NOP_INSTR;
            operand_q     <= '0;
            pm_req_q      <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            fetch_pc      <= fetch_pc_nxt;
            pm_req_q      <= (state_nxt != ISSUE);
            instr_valid_q <= (state_nxt == ISSUE);
            if (ir_load) begin
                ir   <= pm_rdata;
                pc_q <= fetch_pc;
            end
            if (op_load) operand_q <= pm_rdata;
        end
    end

    assign pm_addr     = fetch_pc;
    assign pm_req      = pm_req_q;
    assign instruction = ir;
    assign OP_dk       = ir[15:8];
    assign OP_s        = ir[15:12];
    assign operand     = operand_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;

endmodule
